// File: rtl/clk_en_pkg.sv
// Shared types and constants for the strobe-cadence tracker (clk_en_sync).
package clk_en_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int DEF_SAM_PERIOD      = 4;
    localparam int DEF_SAMPLES_PER_SYM = 4;
    localparam int DEF_LOCK_COUNT      = 2;
    localparam int DEF_ERR_W           = 8;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int sig_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_PHASE_W = sig_width(DEF_SAM_PERIOD);
    localparam int DEF_IDX_W   = sig_width(DEF_SAMPLES_PER_SYM);

endpackage

// File: rtl/clk_en_cadence_chk.sv
// Sample-strobe interval timer: tracks cycles since sam_clk_en and flags
// strobes that arrive early or fail to arrive when due.
module clk_en_cadence_chk
    import clk_en_pkg::*;
#(
    parameter int SAM_PERIOD = DEF_SAM_PERIOD,
    parameter int PHASE_W    = sig_width(SAM_PERIOD)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sam_clk_en,
    output logic [PHASE_W-1:0] sam_phase,
    output logic               sam_err_raw
);

    localparam int TMR_W = $clog2(SAM_PERIOD + 1);

    logic [TMR_W-1:0]   sam_tmr_reg;
    logic [TMR_W-1:0]   sam_tmr_next;
    logic [PHASE_W-1:0] sam_phase_reg;
    logic [PHASE_W-1:0] sam_phase_next;

    always_comb begin
        sam_tmr_next = sam_tmr_reg;
        if (sam_clk_en)
            sam_tmr_next = '0;
        else if (sam_tmr_reg != TMR_W'(SAM_PERIOD))
            sam_tmr_next = sam_tmr_reg + TMR_W'(1);

        sam_phase_next = PHASE_W'(sam_tmr_next);
        if (sam_tmr_next >= TMR_W'(SAM_PERIOD - 1))
            sam_phase_next = PHASE_W'(SAM_PERIOD - 1);

        // Late fires only on the cycle the timer steps into saturation,
        // so a missing strobe is reported exactly once.
        if (sam_clk_en)
            sam_err_raw = (sam_tmr_reg != TMR_W'(SAM_PERIOD - 1));
        else
            sam_err_raw = (sam_tmr_reg == TMR_W'(SAM_PERIOD - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sam_tmr_reg   <= '0;
            sam_phase_reg <= '0;
        end else begin
            sam_tmr_reg   <= sam_tmr_next;
            sam_phase_reg <= sam_phase_next;
        end
    end

    assign sam_phase = sam_phase_reg;

endmodule

// File: rtl/clk_en_sync.sv
// Receive-side strobe tracker: recovers sample index, verifies cadence, declares lock.
// Build option CLK_EN_SYNC_ERR_CNT_EN enables the saturating error-event counter.
module clk_en_sync
    import clk_en_pkg::*;
#(
    parameter int SAM_PERIOD      = DEF_SAM_PERIOD,
    parameter int SAMPLES_PER_SYM = DEF_SAMPLES_PER_SYM,
    parameter int LOCK_COUNT      = DEF_LOCK_COUNT,
    parameter int ERR_W           = DEF_ERR_W,
    parameter int PHASE_W         = sig_width(SAM_PERIOD),
    parameter int IDX_W           = sig_width(SAMPLES_PER_SYM)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sam_clk_en,
    input  logic               sym_clk_en,
    output logic [PHASE_W-1:0] sam_phase,
    output logic [IDX_W-1:0]   sam_idx,
    output logic               locked,
    output logic               sam_err,
    output logic               sym_err,
    output logic [ERR_W-1:0]   err_cnt
);

    localparam int GOOD_W = sig_width(LOCK_COUNT + 1);

    state_t            state_reg;
    logic [IDX_W-1:0]  sam_idx_reg;
    logic [GOOD_W-1:0] good_sym_reg;
    logic              locked_reg;
    logic              sam_err_reg;
    logic              sym_err_reg;

    logic              sam_err_raw;
    logic [IDX_W-1:0]  exp_idx_next;
    logic              checking;
    logic              pair;
    logic              sam_err_c;
    logic              sym_err_c;
    logic              any_err;

    clk_en_cadence_chk #(
        .SAM_PERIOD (SAM_PERIOD),
        .PHASE_W    (PHASE_W)
    ) u_cadence (
        .clk         (clk),
        .reset       (reset),
        .sam_clk_en  (sam_clk_en),
        .sam_phase   (sam_phase),
        .sam_err_raw (sam_err_raw)
    );

    // SAMPLES_PER_SYM is a power of two, so the index wraps naturally.
    always_comb begin
        exp_idx_next = sam_idx_reg + IDX_W'(1);
        checking     = (state_reg != SEARCH);
        pair         = sam_clk_en & sym_clk_en;
        sam_err_c    = checking & sam_err_raw;
        sym_err_c    = checking & ((sym_clk_en & ~sam_clk_en)
                                 | (pair & (exp_idx_next != '0))
                                 | (sam_clk_en & ~sym_clk_en & (exp_idx_next == '0)));
        any_err      = sam_err_c | sym_err_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= SEARCH;
            sam_idx_reg  <= '0;
            good_sym_reg <= '0;
            locked_reg   <= 1'b0;
            sam_err_reg  <= 1'b0;
            sym_err_reg  <= 1'b0;
        end else begin
            sam_err_reg <= sam_err_c;
            sym_err_reg <= sym_err_c;
            case (state_reg)
                SEARCH: begin
                    if (pair) begin
                        state_reg    <= VERIFY;
                        sam_idx_reg  <= '0;
                        good_sym_reg <= '0;
                    end
                end
                default: begin
                    if (any_err) begin
                        locked_reg   <= 1'b0;
                        good_sym_reg <= '0;
                        // A strobe pair on the failing cycle is a fresh symbol start.
                        if (pair) begin
                            state_reg   <= VERIFY;
                            sam_idx_reg <= '0;
                        end else begin
                            state_reg   <= SEARCH;
                        end
                    end else if (pair) begin
                        sam_idx_reg <= '0;
                        if (state_reg == VERIFY) begin
                            good_sym_reg <= good_sym_reg + GOOD_W'(1);
                            if (good_sym_reg + GOOD_W'(1) == GOOD_W'(LOCK_COUNT)) begin
                                state_reg  <= LOCKED;
                                locked_reg <= 1'b1;
                            end
                        end
                    end else if (sam_clk_en) begin
                        sam_idx_reg <= exp_idx_next;
                    end
                end
            endcase
        end
    end

`ifdef CLK_EN_SYNC_ERR_CNT_EN
    logic [ERR_W-1:0] err_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset)
            err_cnt_reg <= '0;
        else if (any_err && (err_cnt_reg != '1))
            err_cnt_reg <= err_cnt_reg + ERR_W'(1);
    end

    assign err_cnt = err_cnt_reg;
`else
    assign err_cnt = '0;
`endif

    assign sam_idx = sam_idx_reg;
    assign locked  = locked_reg;
    assign sam_err = sam_err_reg;
    assign sym_err = sym_err_reg;

endmodule

// File: tb/tb_clk_en_sync.sv
// Directed bench for clk_en_sync: lock acquisition, cadence faults, counter saturation, reset.
module tb_clk_en_sync;
    import clk_en_pkg::*;

`ifdef CLK_EN_SYNC_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sam_clk_en = 1'b0;
    logic       sym_clk_en = 1'b0;
    logic [1:0] sam_phase;
    logic [1:0] sam_idx;
    logic       locked;
    logic       sam_err;
    logic       sym_err;
    logic [7:0] err_cnt;

    int checks = 0;
    int failures = 0;
    int errs = 0;

    clk_en_sync dut (
        .clk        (clk),
        .reset      (reset),
        .sam_clk_en (sam_clk_en),
        .sym_clk_en (sym_clk_en),
        .sam_phase  (sam_phase),
        .sam_idx    (sam_idx),
        .locked     (locked),
        .sam_err    (sam_err),
        .sym_err    (sym_err),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    function automatic logic [31:0] exp_cnt();
        if (!ERR_EN) return 32'd0;
        return (errs > 255) ? 32'd255 : 32'(errs);
    endfunction

    // One clock with the given strobes; outputs are valid on return.
    task automatic tick(input logic s, input logic y);
        sam_clk_en = s;
        sym_clk_en = y;
        @(posedge clk);
        #1;
        sam_clk_en = 1'b0;
        sym_clk_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
    endtask

    task automatic strobe(input logic y);
        idle(3);
        tick(1'b1, y);
    endtask

    task automatic symbol();
        for (int i = 0; i < 3; i++) strobe(1'b0);
        strobe(1'b1);
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        check("rst_phase", sam_phase, 0);
        check("rst_idx", sam_idx, 0);
        check("rst_locked", locked, 0);
        check("rst_sam_err", sam_err, 0);
        check("rst_sym_err", sym_err, 0);
        check("rst_err_cnt", err_cnt, 0);

        // Nominal acquisition
        idle(3);
        check("nom_phase3", sam_phase, 3);
        tick(1'b1, 1'b1);
        check("nom_phase0", sam_phase, 0);
        check("nom_idx0", sam_idx, 0);
        for (int i = 1; i < 4; i++) begin
            strobe(1'b0);
            check("nom_idx", sam_idx, i);
        end
        strobe(1'b1);
        check("nom_idx_wrap", sam_idx, 0);
        check("nom_locked_1sym", locked, 0);
        symbol();
        check("nom_locked", locked, 1);
        check("nom_err_cnt", err_cnt, exp_cnt());
        check("nom_sam_err", sam_err, 0);

        // Early sample strobe while locked
        strobe(1'b0);
        idle(2);
        tick(1'b1, 1'b0);
        errs++;
        check("early_sam_err", sam_err, 1);
        check("early_sym_err", sym_err, 0);
        check("early_locked", locked, 0);
        check("early_err_cnt", err_cnt, exp_cnt());
        idle(1);
        check("early_pulse_end", sam_err, 0);
        strobe(1'b0);
        strobe(1'b1);
        symbol();
        check("early_relock_1sym", locked, 0);
        symbol();
        check("early_relock", locked, 1);

        // Suppressed sample strobe while locked
        strobe(1'b0);
        idle(3);
        check("late_before", sam_err, 0);
        idle(1);
        errs++;
        check("late_sam_err", sam_err, 1);
        check("late_locked", locked, 0);
        check("late_phase_clamp", sam_phase, 3);
        check("late_err_cnt", err_cnt, exp_cnt());
        idle(1);
        check("late_once", sam_err, 0);
        idle(2);
        tick(1'b1, 1'b0);
        check("late_err_cnt_hold", err_cnt, exp_cnt());
        strobe(1'b0);
        strobe(1'b1);
        symbol();
        symbol();
        check("late_relock", locked, 1);

        // Symbol strobe shifted onto sample index 2
        strobe(1'b0);
        strobe(1'b1);
        errs++;
        check("shift_sym_err", sym_err, 1);
        check("shift_sam_err", sam_err, 0);
        check("shift_idx", sam_idx, 0);
        check("shift_locked", locked, 0);
        check("shift_err_cnt", err_cnt, exp_cnt());
        symbol();
        check("shift_verify_1sym", locked, 0);
        symbol();
        check("shift_relock", locked, 1);

        // Reset mid-symbol while locked
        strobe(1'b0);
        strobe(1'b0);
        reset = 1'b1;
        tick(1'b0, 1'b0);
        reset = 1'b0;
        errs = 0;
        check("mrst_phase", sam_phase, 0);
        check("mrst_idx", sam_idx, 0);
        check("mrst_locked", locked, 0);
        check("mrst_err_cnt", err_cnt, 0);
        tick(1'b0, 1'b1);
        check("mrst_stray_sym_err", sym_err, 0);
        strobe(1'b0);
        check("mrst_search_sam_err", sam_err, 0);
        strobe(1'b1);
        check("mrst_pair_idx", sam_idx, 0);
        symbol();
        check("mrst_relock_1sym", locked, 0);
        symbol();
        check("mrst_relock", locked, 1);

        // Back-to-back pairs: one error event per cycle
        for (int i = 0; i < 255; i++) tick(1'b1, 1'b1);
        errs += 255;
        check("sat_255", err_cnt, exp_cnt());
        for (int i = 0; i < 45; i++) tick(1'b1, 1'b1);
        errs += 45;
        check("sat_hold", err_cnt, exp_cnt());
        check("sat_sam_err", sam_err, 1);
        check("sat_sym_err", sym_err, 1);
        check("sat_locked", locked, 0);
        idle(1);
        check("sat_pulse_end", sym_err, 0);
        check("sat_final_cnt", err_cnt, exp_cnt());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
